// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: program counter, redirect/stall arbitration, target range
// checking and the IF/ID pipeline register feeding decode.
module instruction_fetch_stage #(
    parameter int                      DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]   TEXT_BASE    = 32'h0040_0000,
    parameter int                      MEMORY_DEPTH = 'h200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  DecRedirect,
    input  logic [DATA_WIDTH-1:0] DecTarget,
    input  logic                  ExBranchTaken,
    input  logic [DATA_WIDTH-1:0] ExBranchTarget,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] IFID_Instr,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  AddrError
);

    // One extra bit so the end-of-text bound cannot wrap at the top of the space.
    localparam logic [DATA_WIDTH:0] TEXT_END =
        {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0] pc_reg, pc_next;
    logic [DATA_WIDTH-1:0] instr_reg, instr_next;
    logic [DATA_WIDTH-1:0] pcplus4_reg, pcplus4_next;
    logic                  valid_reg, valid_next;
    logic                  err_reg, err_next;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  seq_past_end;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] target;
    logic                  target_ok;

    always_comb begin
        pc_plus4     = pc_reg + DATA_WIDTH'(4);
        seq_past_end = ({1'b0, pc_reg} + (DATA_WIDTH+1)'(4)) >= TEXT_END;
        redirect     = ExBranchTaken | DecRedirect;
        // Execute-stage branch is older than the decode-stage jump, so it wins.
        target       = ExBranchTaken ? ExBranchTarget : DecTarget;
        target_ok    = (target[1:0] == 2'b00) && (target >= TEXT_BASE) &&
                       ({1'b0, target} < TEXT_END);

        pc_next      = pc_reg;
        instr_next   = instr_reg;
        pcplus4_next = pcplus4_reg;
        valid_next   = valid_reg;
        err_next     = err_reg;

        if (err_reg) begin
            instr_next   = '0;
            pcplus4_next = '0;
            valid_next   = 1'b0;
        end else if (redirect) begin
            instr_next   = '0;
            pcplus4_next = '0;
            valid_next   = 1'b0;
            if (target_ok) begin
                pc_next = target;
            end else begin
                err_next = 1'b1;
            end
        end else if (Stall) begin
            if (Flush) begin
                instr_next   = '0;
                pcplus4_next = '0;
                valid_next   = 1'b0;
            end
        end else begin
            // The last word is still a legal fetch; only the step past it traps.
            if (seq_past_end) begin
                err_next = 1'b1;
            end else begin
                pc_next = pc_plus4;
            end
            if (Flush) begin
                instr_next   = '0;
                pcplus4_next = '0;
                valid_next   = 1'b0;
            end else begin
                instr_next   = Instruction;
                pcplus4_next = pc_plus4;
                valid_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg      <= TEXT_BASE;
            instr_reg   <= '0;
            pcplus4_reg <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            pcplus4_reg <= pcplus4_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
        end
    end

    assign PC           = pc_reg;
    assign IFID_Instr   = instr_reg;
    assign IFID_PCPlus4 = pcplus4_reg;
    assign IFID_Valid   = valid_reg;
    assign AddrError    = err_reg;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: a ROM model answers fetches, the
// stimulus queues expected IF/ID words and a monitor checks what decode accepts.
module tb_instruction_fetch_stage;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] TEND = 32'h0040_0800;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        DecRedirect = 1'b0;
    logic [31:0] DecTarget = '0;
    logic        ExBranchTaken = 1'b0;
    logic [31:0] ExBranchTarget = '0;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        AddrError;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];

    instruction_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .Stall          (Stall),
        .Flush          (Flush),
        .DecRedirect    (DecRedirect),
        .DecTarget      (DecTarget),
        .ExBranchTaken  (ExBranchTaken),
        .ExBranchTarget (ExBranchTarget),
        .Instruction    (Instruction),
        .PC             (PC),
        .IFID_Instr     (IFID_Instr),
        .IFID_PCPlus4   (IFID_PCPlus4),
        .IFID_Valid     (IFID_Valid),
        .AddrError      (AddrError)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a >= BASE && a < TEND) return 32'hA500_0000 | ((a - BASE) >> 2);
        return 32'h0;
    endfunction

    assign Instruction = rom_word(PC);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        sb.push_back({rom_word(a), a + 32'd4});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Decode accepts the IF/ID word in any cycle it is valid and not stalled.
    always @(negedge clk) begin
        if (!reset && IFID_Valid && !Stall) begin
            if (sb.size() == 0) begin
                chk("unexpected_ifid", IFID_Instr, 32'h0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                $display("ifid accept: instr=%h pcplus4=%h", IFID_Instr, IFID_PCPlus4);
                chk("ifid_instr", IFID_Instr, e[63:32]);
                chk("ifid_pcplus4", IFID_PCPlus4, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc();
        cyc();
        chk("rst_pc", PC, BASE);
        chk("rst_instr", IFID_Instr, 32'h0);
        chk("rst_pcplus4", IFID_PCPlus4, 32'h0);
        chk("rst_valid", {31'b0, IFID_Valid}, 32'h0);
        chk("rst_err", {31'b0, AddrError}, 32'h0);

        // Free-run A, B
        reset = 1'b0;
        push(32'h0040_0000);
        cyc(); chk("run_pc1", PC, 32'h0040_0004);
        push(32'h0040_0004);
        cyc(); chk("run_pc2", PC, 32'h0040_0008);

        // Two-cycle stall at 0x00400008
        Stall = 1'b1;
        cyc(); chk("stall_pc1", PC, 32'h0040_0008);
        chk("stall_instr", IFID_Instr, rom_word(32'h0040_0004));
        cyc(); chk("stall_pc2", PC, 32'h0040_0008);
        chk("stall_pcplus4", IFID_PCPlus4, 32'h0040_0008);
        Stall = 1'b0;
        push(32'h0040_0008);
        cyc(); chk("release_pc", PC, 32'h0040_000C);
        cyc(); chk("run_pc3", PC, 32'h0040_0010);

        // Decode jump together with stall
        DecRedirect = 1'b1; DecTarget = 32'h0040_0040; Stall = 1'b1;
        cyc(); chk("jmp_pc", PC, 32'h0040_0040);
        chk("jmp_valid", {31'b0, IFID_Valid}, 32'h0);
        chk("jmp_instr", IFID_Instr, 32'h0);
        DecRedirect = 1'b0; Stall = 1'b0;
        push(32'h0040_0040);
        cyc(); chk("jmp_next_pc", PC, 32'h0040_0044);

        // Branch beats jump
        ExBranchTaken = 1'b1; ExBranchTarget = 32'h0040_0100;
        DecRedirect = 1'b1;   DecTarget = 32'h0040_0200;
        cyc(); chk("br_pc", PC, 32'h0040_0100);
        chk("br_valid", {31'b0, IFID_Valid}, 32'h0);
        ExBranchTaken = 1'b0; DecRedirect = 1'b0;
        push(32'h0040_0100);
        cyc(); chk("br_next_pc", PC, 32'h0040_0104);

        // Misaligned target traps; later redirects ignored
        DecRedirect = 1'b1; DecTarget = 32'h0040_0042;
        cyc(); chk("mis_pc", PC, 32'h0040_0104);
        chk("mis_err", {31'b0, AddrError}, 32'h1);
        chk("mis_valid", {31'b0, IFID_Valid}, 32'h0);
        DecRedirect = 1'b0; ExBranchTaken = 1'b1; ExBranchTarget = 32'h0040_0000;
        cyc(); chk("err_hold_pc", PC, 32'h0040_0104);
        chk("err_hold_err", {31'b0, AddrError}, 32'h1);
        chk("err_hold_valid", {31'b0, IFID_Valid}, 32'h0);

        // Reset with a redirect still asserted
        reset = 1'b1;
        cyc(); chk("rst2_pc", PC, BASE);
        chk("rst2_err", {31'b0, AddrError}, 32'h0);
        chk("rst2_valid", {31'b0, IFID_Valid}, 32'h0);
        reset = 1'b0; ExBranchTaken = 1'b0;
        push(32'h0040_0000);
        cyc(); chk("rst2_run_pc", PC, 32'h0040_0004);

        // Flush alone, then Flush with Stall
        Flush = 1'b1;
        cyc(); chk("flush_pc", PC, 32'h0040_0008);
        chk("flush_valid", {31'b0, IFID_Valid}, 32'h0);
        Stall = 1'b1;
        cyc(); chk("flush_stall_pc", PC, 32'h0040_0008);
        chk("flush_stall_valid", {31'b0, IFID_Valid}, 32'h0);
        Flush = 1'b0; Stall = 1'b0;

        // Run to the end of program memory
        for (logic [31:0] a = 32'h0040_0008; a < 32'h0040_07FC; a += 32'd4) begin
            push(a);
            cyc(); chk("seq_pc", PC, a + 32'd4);
        end
        push(32'h0040_07FC);
        cyc(); chk("end_pc", PC, 32'h0040_07FC);
        chk("end_err", {31'b0, AddrError}, 32'h1);
        chk("end_instr", IFID_Instr, rom_word(32'h0040_07FC));
        cyc(); chk("end_hold_pc", PC, 32'h0040_07FC);
        chk("end_bubble", {31'b0, IFID_Valid}, 32'h0);

        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
